// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_sup_state_t;

  // Width of the shared timer; the timer only ever counts to (largest cycle count - 1).
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? int'($clog2(m)) : 1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level; resets to 0.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencing, lock timeout/retry and lock qualification ahead of
// releasing the core reset. Runs entirely on the PLL reference clock.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC   = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC = 1024,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                             refclk,
  input  logic                             rst_n,
  input  logic                             pll_locked,
  input  logic                             sw_relock,
  output logic                             pll_rst,
  output logic                             sys_reset,
  output logic                             ready,
  output logic                             fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic [2:0]                       state_o
);

  localparam int unsigned TW = timer_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam int unsigned RW = $clog2(MAX_RETRIES+1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  pll_sup_state_t state, state_nxt;
  logic [TW-1:0]  timer;
  logic [RW-1:0]  retry_nxt;
  logic           timer_clr;
  logic           locked_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // Timer only runs in the timed states so it cannot wrap while parked in RUN/FAIL.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      timer <= '0;
    else if (timer_clr)
      timer <= '0;
    else if (state == RESET_PLL || state == WAIT_LOCK || state == STABILIZE)
      timer <= timer + TW'(1);
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    timer_clr = 1'b0;
    if (sw_relock) begin
      state_nxt = RESET_PLL;
      retry_nxt = '0;
      timer_clr = 1'b1;
    end else begin
      unique case (state)
        RESET_PLL: if (timer == RST_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = STABILIZE;
          end else if (timer == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = FAIL;
            end else begin
              state_nxt = RESET_PLL;
              retry_nxt = retry_cnt + RW'(1);
            end
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
          end else if (timer == STABLE_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end
        end
        RUN:     if (!locked_s) state_nxt = RESET_PLL;
        FAIL:    state_nxt = FAIL;
        default: state_nxt = RESET_PLL;
      endcase
    end
    if (state_nxt != state) timer_clr = 1'b1;
  end

  always_comb begin
    pll_rst   = (state == RESET_PLL);
    sys_reset = (state != RUN);
    ready     = (state == RUN);
    fail      = (state == FAIL);
    state_o   = state;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a per-cycle reference model.
module tb_pll_lock_supervisor;

  localparam int unsigned RP = 4;
  localparam int unsigned TO = 20;
  localparam int unsigned ST = 8;
  localparam int unsigned MR = 2;
  localparam int unsigned SS = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_relock = 1'b0;
  logic       pll_rst, sys_reset, ready, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE_CYC   (RP),
    .LOCK_TIMEOUT_CYC(TO),
    .LOCK_STABLE_CYC (ST),
    .MAX_RETRIES     (MR),
    .SYNC_STAGES     (SS)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .sw_relock (sw_relock),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .state_o   (state_o)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Reference model: phase number (0 reset pulse, 1 waiting, 2 qualifying,
  // 3 running, 4 failed) with a countdown of cycles left in the phase.
  int   m_ph = 0;
  int   m_left = RP;
  int   m_retries = 0;
  logic m_sync[SS];
  logic m_ls;

  initial begin
    for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
    forever begin
      @(posedge refclk or negedge rst_n);
      if (!rst_n) begin
        m_ph = 0; m_left = RP; m_retries = 0;
        for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
      end else begin
        m_ls = m_sync[SS-1];
        for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = pll_locked;
        if (sw_relock) begin
          m_ph = 0; m_left = RP; m_retries = 0;
        end else if (m_ph == 0) begin
          m_left--;
          if (m_left == 0) begin m_ph = 1; m_left = TO; end
        end else if (m_ph == 1) begin
          if (m_ls) begin
            m_ph = 2; m_left = ST;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_retries >= MR) m_ph = 4;
              else begin m_retries++; m_ph = 0; m_left = RP; end
            end
          end
        end else if (m_ph == 2) begin
          if (!m_ls) begin
            m_ph = 1; m_left = TO;
          end else begin
            m_left--;
            if (m_left == 0) begin m_ph = 3; m_retries = 0; end
          end
        end else if (m_ph == 3) begin
          if (!m_ls) begin m_ph = 0; m_left = RP; end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge refclk);
      check("cmp_state",     int'(state_o),   m_ph);
      check("cmp_pll_rst",   int'(pll_rst),   (m_ph == 0) ? 1 : 0);
      check("cmp_sys_reset", int'(sys_reset), (m_ph == 3) ? 0 : 1);
      check("cmp_ready",     int'(ready),     (m_ph == 3) ? 1 : 0);
      check("cmp_fail",      int'(fail),      (m_ph == 4) ? 1 : 0);
      check("cmp_retry",     int'(retry_cnt), m_retries);
    end
  end

  initial begin
    int first_low, first_ready, stab, pulses, high, first_fail, sys_low;
    int r10, r30, r60, entries, prev_st, st14, rt14;
    int rises[$];
    int stab_in[$];
    logic prev;

    // Reset values
    rst_n = 1'b0; pll_locked = 1'b1; sw_relock = 1'b0;
    repeat (3) tick();
    check("rst_state", int'(state_o), 0);
    check("rst_pll_rst", int'(pll_rst), 1);
    check("rst_sys_reset", int'(sys_reset), 1);
    check("rst_ready", int'(ready), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_retry", int'(retry_cnt), 0);

    // Nominal lock
    rst_n = 1'b1;
    first_low = 0; first_ready = 0; stab = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!pll_rst && first_low == 0) first_low = i;
      if (ready && first_ready == 0) first_ready = i;
      if (state_o == 3'd2) stab++;
    end
    check("nom_rst_pulse_len", first_low, 4);
    check("nom_ready_cycle", first_ready, 13);
    check("nom_stab_len", stab, 8);
    check("nom_retry", int'(retry_cnt), 0);
    check("nom_sys_reset", int'(sys_reset), 0);

    // Asynchronous reset in the middle of STABILIZE
    rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1;
    repeat (8) tick();
    check("ar_in_stab", int'(state_o), 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_state", int'(state_o), 0);
    check("ar_pll_rst", int'(pll_rst), 1);
    check("ar_sys_reset", int'(sys_reset), 1);
    check("ar_ready", int'(ready), 0);
    tick(); tick();

    // No lock: three attempts then FAIL
    pll_locked = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses = pll_rst ? 1 : 0; high = pll_rst ? 1 : 0; prev = pll_rst;
    first_fail = 0; sys_low = 0; r10 = -1; r30 = -1; r60 = -1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (pll_rst && !prev) begin pulses++; rises.push_back(i); end
      if (pll_rst) high++;
      prev = pll_rst;
      if (fail && first_fail == 0) first_fail = i;
      if (!sys_reset) sys_low++;
      if (i == 10) r10 = int'(retry_cnt);
      if (i == 30) r30 = int'(retry_cnt);
      if (i == 60) r60 = int'(retry_cnt);
    end
    check("nl_pulses", pulses, 3);
    check("nl_rst_high_total", high, 12);
    check("nl_rise2", (rises.size() > 0) ? rises[0] : -1, 24);
    check("nl_rise3", (rises.size() > 1) ? rises[1] : -1, 48);
    check("nl_fail_cycle", first_fail, 72);
    check("nl_sys_low", sys_low, 0);
    check("nl_retry0", r10, 0);
    check("nl_retry1", r30, 1);
    check("nl_retry2", r60, 2);

    // Recovery from FAIL
    pll_locked = 1'b1;
    repeat (3) tick();
    check("rc_still_fail", int'(fail), 1);
    sw_relock = 1'b1; tick(); sw_relock = 1'b0;
    check("rc_fail_clr", int'(fail), 0);
    check("rc_retry", int'(retry_cnt), 0);
    check("rc_state", int'(state_o), 0);
    high = 1; first_ready = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (pll_rst) high++;
      if (ready && first_ready == 0) first_ready = i;
    end
    check("rc_rst_pulse_len", high, 4);
    check("rc_ready_cycle", first_ready, 13);

    // Lock loss in RUN (one-cycle drop)
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1; tick();
    check("ll_still_run", int'(state_o), 3);
    tick();
    check("ll_state", int'(state_o), 0);
    check("ll_sys_reset", int'(sys_reset), 1);
    check("ll_pll_rst", int'(pll_rst), 1);
    first_ready = 0;
    for (int i = 4; i <= 20; i++) begin
      tick();
      if (ready && first_ready == 0) first_ready = i;
    end
    check("ll_ready_cycle", first_ready, 16);

    // sw_relock coincident with a lock drop reaching the FSM in RUN
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1; tick();
    check("co_pre_run", int'(state_o), 3);
    sw_relock = 1'b1; tick(); sw_relock = 1'b0;
    check("co_state", int'(state_o), 0);
    entries = 1; prev_st = 0; first_ready = 0;
    for (int i = 4; i <= 25; i++) begin
      tick();
      if (state_o == 3'd0 && prev_st != 0) entries++;
      prev_st = int'(state_o);
      if (ready && first_ready == 0) first_ready = i;
    end
    check("co_reset_entries", entries, 1);
    check("co_ready_cycle", first_ready, 16);

    // Glitchy lock in STABILIZE
    rst_n = 1'b0; pll_locked = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    prev_st = 0; first_ready = 0; sys_low = 0; st14 = -1; rt14 = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (state_o == 3'd2 && prev_st != 2) stab_in.push_back(i);
      prev_st = int'(state_o);
      if (ready && first_ready == 0) first_ready = i;
      if (!sys_reset && i < 26) sys_low++;
      if (i == 14) begin st14 = int'(state_o); rt14 = int'(retry_cnt); end
      if (i == 5)  pll_locked = 1'b1;
      if (i == 11) pll_locked = 1'b0;
      if (i == 15) pll_locked = 1'b1;
    end
    check("gl_stab_entry1", (stab_in.size() > 0) ? stab_in[0] : -1, 8);
    check("gl_back_to_wait", st14, 1);
    check("gl_retry", rt14, 0);
    check("gl_stab_entry2", (stab_in.size() > 1) ? stab_in[1] : -1, 18);
    check("gl_ready_cycle", first_ready, 26);
    check("gl_sys_low_early", sys_low, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
